// File: rtl/cordic_ser_pkg.sv
// Shared types for the CORDIC result serializer.
// Frame: start, LSB-first value, mode tag, stop.
package cordic_ser_pkg;

  localparam int RES_W      = 11;
  localparam int FRAME_BITS = 14;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    TAG,
    STOP
  } state_t;

  typedef struct packed {
    logic             mode;
    logic [RES_W-1:0] val;
  } entry_t;

endpackage

// File: rtl/cordic_res_fifo.sv
// Circular result FIFO; a push while full is dropped
// unless a pop frees the slot on the same edge.
module cordic_res_fifo
  import cordic_ser_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  entry_t        wdata,
  output entry_t        rdata,
  output logic [CW-1:0] count,
  output logic          full
);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          wr;

  assign full  = count == CW'(DEPTH);
  assign wr    = push & (~full | pop);
  assign rdata = mem[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr)  wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= wdata;
  end

endmodule

// File: rtl/cordic_result_serializer.sv
// Captures CORDIC results on the done rise and streams
// them out as framed LSB-first serial bits on tx_out.
module cordic_result_serializer
  import cordic_ser_pkg::*;
#(
  parameter  int DATA_W   = RES_W,
  parameter  int DEPTH    = 4,
  parameter  int BAUD_DIV = 4,
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] res_val,
  input  logic              res_done,
  input  logic              res_mode,
  input  logic              clr_ovf,
  output logic              tx_out,
  output logic              tx_busy,
  output logic [CW-1:0]     fifo_count,
  output logic              overflow
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int NW = $clog2(DATA_W);
  localparam logic [BW-1:0] BLAST = BW'(BAUD_DIV - 1);
  localparam logic [NW-1:0] NLAST = NW'(DATA_W - 1);

  state_t            state;
  logic              done_prev;
  logic              push;
  logic              pop;
  logic              full;
  logic              bend;
  logic              mode_q;
  logic [BW-1:0]     bcnt;
  logic [NW-1:0]     nbit;
  logic [DATA_W-1:0] shreg;
  entry_t            wdata;
  entry_t            rdata;

  assign push    = res_done & ~done_prev;
  assign pop     = (state == IDLE) && (fifo_count != '0);
  assign bend    = bcnt == BLAST;
  assign tx_busy = state != IDLE;
  assign wdata   = {res_mode, res_val};

  cordic_res_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .count (fifo_count),
    .full  (full)
  );

  // done_prev resets high so a level held through reset is not a result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_prev <= 1'b1;
      overflow  <= 1'b0;
    end else begin
      done_prev <= res_done;
      if (push & full & ~pop) overflow <= 1'b1;
      else if (clr_ovf)       overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      tx_out <= 1'b1;
      bcnt   <= '0;
      nbit   <= '0;
      shreg  <= '0;
      mode_q <= 1'b0;
    end else begin
      bcnt <= (state == IDLE || bend) ? '0 : bcnt + 1'b1;
      case (state)
        IDLE: begin
          tx_out <= 1'b1;
          if (pop) begin
            state  <= START;
            tx_out <= 1'b0;
            shreg  <= rdata.val;
            mode_q <= rdata.mode;
            nbit   <= '0;
          end
        end
        START: if (bend) begin
          state  <= DATA;
          tx_out <= shreg[0];
          shreg  <= shreg >> 1;
        end
        DATA: if (bend) begin
          if (nbit == NLAST) begin
            state  <= TAG;
            tx_out <= mode_q;
          end else begin
            nbit   <= nbit + 1'b1;
            tx_out <= shreg[0];
            shreg  <= shreg >> 1;
          end
        end
        TAG: if (bend) begin
          state  <= STOP;
          tx_out <= 1'b1;
        end
        STOP: if (bend) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_result_serializer.sv
// Scoreboard bench: timing model predicts FIFO/busy state,
// a serial receiver decodes frames and checks them.
module tb_cordic_result_serializer;

  localparam int DW    = 11;
  localparam int DEPTH = 4;
  localparam int B     = 4;
  localparam int FB    = 14 * B;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] res_val = '0;
  logic          res_done = 1'b0;
  logic          res_mode = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          tx_out;
  logic          tx_busy;
  logic [2:0]    fifo_count;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  logic [DW:0] mq[$];
  logic [DW:0] sb[$];
  int cyc = 0;
  int free_at = 0;
  int busy_until = 0;
  bit prev_m = 1'b1;
  bit ovf_m = 1'b0;
  int frames = 0;
  int peak = 0;

  cordic_result_serializer #(
    .DATA_W   (DW),
    .DEPTH    (DEPTH),
    .BAUD_DIV (B)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .res_val    (res_val),
    .res_done   (res_done),
    .res_mode   (res_mode),
    .clr_ovf    (clr_ovf),
    .tx_out     (tx_out),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: results queue up, and the line is free again one
  // idle clock after a 14-bit frame that starts the edge after pop.
  initial begin
    bit pu, po, dr;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        sb.delete();
        prev_m = 1'b1;
        ovf_m = 1'b0;
        cyc = 0;
        free_at = 0;
        busy_until = 0;
      end else begin
        cyc++;
        po = (cyc >= free_at) && (mq.size() > 0);
        pu = res_done && !prev_m;
        prev_m = res_done;
        if (po) begin
          mq.delete(0);
          busy_until = cyc + FB;
          free_at = cyc + FB + 1;
        end
        dr = pu && (mq.size() >= DEPTH);
        if (dr) ovf_m = 1'b1;
        else if (clr_ovf) ovf_m = 1'b0;
        if (pu && !dr) begin
          mq.push_back({res_mode, res_val});
          sb.push_back({res_mode, res_val});
        end
      end
    end
  end

  // Monitor: per-cycle status compare plus a serial frame receiver.
  initial begin
    bit          act;
    int          cnt;
    logic [13:0] bits;
    logic [DW:0] exp;
    act = 1'b0;
    cnt = 0;
    bits = '0;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        act = 1'b0;
        cnt = 0;
      end else begin
        chk("fifo_count", fifo_count, mq.size());
        chk("overflow", overflow, ovf_m);
        chk("tx_busy", tx_busy, cyc < busy_until);
        if (!(cyc < busy_until)) chk("idle_high", tx_out, 1);
        if (int'(fifo_count) > peak) peak = fifo_count;
        if (act) cnt++;
        else if (tx_out == 1'b0) begin
          act = 1'b1;
          cnt = 0;
        end
        if (act && (cnt % B) == (B / 2)) begin
          bits[cnt / B] = tx_out;
          if (cnt / B == 13) begin
            act = 1'b0;
            chk("start_bit", bits[0], 0);
            chk("stop_bit", bits[13], 1);
            chk("frame_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
              exp = sb.pop_front();
              chk("frame_data", {bits[12], bits[11:1]}, exp);
            end
            frames++;
          end
        end
      end
    end
  end

  task automatic rise(input logic [DW-1:0] v, input bit m);
    res_val = v;
    res_mode = m;
    res_done = 1'b1;
    @(negedge clk);
    res_done = 1'b0;
    res_val = DW'($urandom);
    res_mode = 1'($urandom);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((mq.size() > 0 || cyc < busy_until) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", n < 5000, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int f0;
    int n;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_tx", tx_out, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_cnt", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    repeat (50) @(negedge clk);

    // single frame 5A3 / sin
    f0 = frames;
    rise(11'h5A3, 1'b1);
    n = 0;
    while (tx_busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("busy_len", n, FB);
    drain();
    chk("frames_5a3", frames - f0, 1);

    // done held high across reset release
    #2 rst_n = 1'b0;
    res_done = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("held_cnt", fifo_count, 0);
    chk("held_busy", tx_busy, 0);
    res_done = 1'b0;
    @(negedge clk);
    f0 = frames;
    rise(11'h001, 1'b0);
    drain();
    chk("frames_held", frames - f0, 1);

    // six results during one frame: sixth dropped
    f0 = frames;
    peak = 0;
    for (int i = 1; i <= 6; i++) rise(DW'(i), 1'($urandom));
    drain();
    chk("ovf_set", overflow, 1);
    chk("peak_cnt", peak, DEPTH);
    chk("frames_six", frames - f0, 5);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    @(negedge clk);
    chk("ovf_clr", overflow, 0);

    // full FIFO with a done rise on the pop edge
    f0 = frames;
    for (int i = 0; i < 5; i++) rise(DW'(11'h100 + i), 1'b1);
    chk("full_cnt", fifo_count, DEPTH);
    n = 0;
    while (cyc != free_at - 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("pop_wait", n < 200, 1);
    rise(11'h7FF, 1'b0);
    chk("full_pop_ovf", overflow, 0);
    drain();
    chk("frames_fullpop", frames - f0, 6);

    // reset pulse mid-DATA
    rise(11'h3C5, 1'b0);
    rise(11'h0AA, 1'b1);
    repeat (18) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_tx", tx_out, 1);
    chk("abort_busy", tx_busy, 0);
    chk("abort_cnt", fifo_count, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    f0 = frames;
    rise(11'h2C7, 1'b1);
    drain();
    chk("frames_after_rst", frames - f0, 1);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(1, 70)) @(negedge clk);
      if ($urandom_range(0, 4) == 0) begin
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
      end
      rise(DW'($urandom), 1'($urandom));
    end
    drain();
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
